dac_serial_tx: RTL and testbench

Transmit-side driver for a DAC7611-style 12-bit serial DAC. It accepts parallel samples on a valid/ready handshake and shifts each one out MSB first on dac_dat/dac_clk. It then pulses dac_leb so the DAC latches the word. It sits between the audio mixer/PSG output stage and the DAC pins.

---
 rtl/dac_serial_pkg.sv | 21 ++
 rtl/dac_serial_tick_div.sv | 40 ++++
 rtl/dac_serial_tx.sv | 171 +++++++++++++++++
 tb/tb_dac_serial_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_serial_pkg.sv
// ---------------------------------------------------------------------------
// dac_serial_pkg
// Shared types and constants for the DAC7611-style serial transmitter.
//   state_t            : frame sequencer states
//   DAC_DATA_W         : native DAC word width
//   FRAME_HALF_PERIODS : serial half-periods per frame (shift + latch + gap)
// ---------------------------------------------------------------------------
package dac_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_HI,
    SHIFT_LO,
    LATCH,
    GAP
  } state_t;

  localparam int DAC_DATA_W         = 12;
  localparam int FRAME_HALF_PERIODS = 2 * DAC_DATA_W + 2;

endpackage

// File: rtl/dac_serial_tick_div.sv
// ---------------------------------------------------------------------------
// dac_serial_tick_div
// Free-running divide-by-CLK_DIV counter producing a one-cycle tick that
// paces the serial half-periods.
//   clk     : system clock
//   rst     : asynchronous reset, active-high
//   restart : synchronous restart, counter returns to 0 on the next edge
//   tick    : high for one cycle every CLK_DIV clocks
// ---------------------------------------------------------------------------
module dac_serial_tick_div
  import dac_serial_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is decoded from the counter register, so the consumer acts on the
  // edge CLK_DIV clocks after the restart edge.
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// ---------------------------------------------------------------------------
// dac_serial_tx
// Serialises parallel samples MSB first to a DAC7611-style 12-bit DAC and
// pulses the load-enable so the DAC latches the word.
//   clk, rst      : system clock, asynchronous active-high reset
//   sample        : offset-binary sample, captured on the accept edge
//   sample_valid  : sample is presented
//   sample_ready  : block accepts a sample this cycle
//   busy          : a frame (shift + latch + gap) is in progress
//   dac_clk       : serial clock, DAC samples dac_dat on its rising edge
//   dac_dat       : serial data, MSB first
//   dac_leb       : load enable, idle high, DAC latches on its rising edge
//   dac_rst_b     : DAC reset, active-low, registered copy of ~rst
// Optional build macro DAC_SERIAL_TX_HOLD_EN adds a one-entry hold register
// so back-to-back frames run with no idle cycle between them.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module dac_serial_tx
  import dac_serial_pkg::*;
#(
  parameter int DATA_W  = DAC_DATA_W,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              busy,
  output logic              dac_clk,
  output logic              dac_dat,
  output logic              dac_leb,
  output logic              dac_rst_b
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BCNT_W-1:0] bit_cnt;
  logic              tick;
  logic              accept;
  logic              load_en;
  logic [DATA_W-1:0] load_word;

  assign accept = sample_valid & sample_ready;

  dac_serial_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .rst     (rst),
    .restart (load_en),
    .tick    (tick)
  );

`ifdef DAC_SERIAL_TX_HOLD_EN
  logic              hold_full;
  logic [DATA_W-1:0] hold_q;

  // A new frame starts from IDLE on accept, or directly from the GAP tick
  // using the held word (or a word offered on that very edge).
  always_comb begin
    load_en   = 1'b0;
    load_word = sample;
    if (state == IDLE) begin
      load_en = accept;
    end else if ((state == GAP) && tick) begin
      load_en = hold_full | accept;
    end
    if (hold_full) begin
      load_word = hold_q;
    end
  end

  // Samples accepted while a frame is running park in the hold register;
  // sample_ready is the registered inverse of the hold occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_q       <= '0;
      sample_ready <= 1'b0;
    end else if (load_en && hold_full) begin
      hold_full    <= 1'b0;
      sample_ready <= 1'b1;
    end else if (accept && !load_en) begin
      hold_q       <= sample;
      hold_full    <= 1'b1;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= !hold_full;
    end
  end
`else
  always_comb begin
    load_en   = (state == IDLE) & accept;
    load_word = sample;
  end

  // Ready only in IDLE; it is raised on the edge that enters IDLE so the
  // flop already reads 1 during the first IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_ready <= 1'b0;
    end else if (load_en) begin
      sample_ready <= 1'b0;
    end else if ((state == IDLE) || ((state == GAP) && tick)) begin
      sample_ready <= 1'b1;
    end
  end
`endif

  // Frame sequencer: one serial half-period per tick. The MSB is presented
  // on the load edge so it is stable before the first dac_clk rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      dac_clk   <= 1'b0;
      dac_dat   <= 1'b0;
      dac_leb   <= 1'b1;
      dac_rst_b <= 1'b0;
    end else begin
      dac_rst_b <= 1'b1;
      if (load_en) begin
        state   <= SHIFT_HI;
        shreg   <= load_word;
        dac_dat <= load_word[DATA_W-1];
        bit_cnt <= '0;
        busy    <= 1'b1;
        dac_clk <= 1'b0;
        dac_leb <= 1'b1;
      end else if (tick) begin
        case (state)
          SHIFT_HI: begin
            dac_clk <= 1'b1;
            state   <= SHIFT_LO;
          end
          SHIFT_LO: begin
            dac_clk <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              dac_dat <= 1'b0;
              dac_leb <= 1'b0;
              state   <= LATCH;
            end else begin
              dac_dat <= shreg[DATA_W-2];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              state   <= SHIFT_HI;
            end
          end
          LATCH: begin
            dac_leb <= 1'b1;
            state   <= GAP;
          end
          GAP: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_dac_serial_tx
// Directed bench for dac_serial_tx: one instance at CLK_DIV=2 and one at
// CLK_DIV=1, each feeding a behavioural DAC7611 model. Expectations follow
// the DAC_SERIAL_TX_HOLD_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_dac_serial_tx;
  import dac_serial_pkg::*;

`ifdef DAC_SERIAL_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [11:0] sample, sample_1;
  logic        sample_valid, sample_valid_1;
  logic        sample_ready, sample_ready_1;
  logic        busy, busy_1;
  logic        dac_clk, dac_clk_1;
  logic        dac_dat, dac_dat_1;
  logic        dac_leb, dac_leb_1;
  logic        dac_rst_b, dac_rst_b_1;

  int checks = 0;
  int errors = 0;

  dac_serial_tx #(.DATA_W(12), .CLK_DIV(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .dac_clk      (dac_clk),
    .dac_dat      (dac_dat),
    .dac_leb      (dac_leb),
    .dac_rst_b    (dac_rst_b)
  );

  dac_serial_tx #(.DATA_W(12), .CLK_DIV(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample_1),
    .sample_valid (sample_valid_1),
    .sample_ready (sample_ready_1),
    .busy         (busy_1),
    .dac_clk      (dac_clk_1),
    .dac_dat      (dac_dat_1),
    .dac_leb      (dac_leb_1),
    .dac_rst_b    (dac_rst_b_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and accept tracking; events are stamped with the number
  // of the clk edge that produced them.
  int cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, rise_base = 0;
  int acc_cnt_1 = 0, acc_cyc_1 = 0, rise_base_1 = 0;
  int rise_cnt = 0, first_rise = 0, rise_cnt_1 = 0, first_rise_1 = 0;
  int leb_fall = 0, leb_rise = 0, prev_leb_rise = 0, latch_cnt = 0;
  int leb_rise_1 = 0, latch_cnt_1 = 0;
  int busy_fall = 0, busy_fall_1 = 0;
  logic [11:0] sr = '0, latch = '0, prev_latch = '0;
  logic [11:0] sr_1 = '0, latch_1 = '0;

  always @(posedge clk) begin
    cyc++;
    if (sample_valid && sample_ready) begin
      acc_cnt++;
      acc_cyc   = cyc;
      rise_base = rise_cnt;
    end
    if (sample_valid_1 && sample_ready_1) begin
      acc_cnt_1++;
      acc_cyc_1   = cyc;
      rise_base_1 = rise_cnt_1;
    end
  end

  // DAC7611 models: shift on dac_clk rise, latch on dac_leb rise,
  // cleared while dac_rst_b is low.
  always @(posedge dac_clk) begin
    sr = {sr[10:0], dac_dat};
    rise_cnt++;
    if (rise_cnt - rise_base == 1) first_rise = cyc;
  end

  always @(negedge dac_leb) leb_fall = cyc;

  always @(posedge dac_leb or negedge dac_rst_b) begin
    if (dac_rst_b !== 1'b1) begin
      latch = '0;
      sr    = '0;
    end else begin
      prev_latch    = latch;
      latch         = sr;
      prev_leb_rise = leb_rise;
      leb_rise      = cyc;
      latch_cnt++;
    end
  end

  always @(negedge busy) busy_fall = cyc;

  always @(posedge dac_clk_1) begin
    sr_1 = {sr_1[10:0], dac_dat_1};
    rise_cnt_1++;
    if (rise_cnt_1 - rise_base_1 == 1) first_rise_1 = cyc;
  end

  always @(posedge dac_leb_1 or negedge dac_rst_b_1) begin
    if (dac_rst_b_1 !== 1'b1) begin
      latch_1 = '0;
      sr_1    = '0;
    end else begin
      latch_1    = sr_1;
      leb_rise_1 = cyc;
      latch_cnt_1++;
    end
  end

  always @(negedge busy_1) busy_fall_1 = cyc;

  task automatic applyStimulus(input int unit, input logic [11:0] data, input logic valid);
    if (unit == 0) begin
      sample       = data;
      sample_valid = valid;
    end else begin
      sample_1       = data;
      sample_valid_1 = valid;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Bounded wait for the CLK_DIV=2 instance to go idle; a timeout shows up
  // as a failing busy comparison.
  task automatic waitIdle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput(tag, busy, 0);
  endtask

  int base, lbase, first_acc, bad_ready;

  initial begin
    rst = 1'b1;
    applyStimulus(0, 12'h000, 1'b0);
    applyStimulus(1, 12'h000, 1'b0);
    repeat (2) @(negedge clk);

    // Reset values {dac_clk,dac_dat,dac_leb,dac_rst_b,sample_ready,busy}
    checkOutput("reset_outs", {dac_clk, dac_dat, dac_leb, dac_rst_b, sample_ready, busy}, 6'b001000);
    checkOutput("reset_outs_div1", {dac_clk_1, dac_dat_1, dac_leb_1, dac_rst_b_1, sample_ready_1, busy_1}, 6'b001000);

    rst = 1'b0;
    #1;
    checkOutput("rst_b_before_edge", dac_rst_b, 0);
    @(negedge clk);
    checkOutput("post_reset", {dac_rst_b, sample_ready, busy}, 3'b110);
    checkOutput("post_reset_div1", {dac_rst_b_1, sample_ready_1, busy_1}, 3'b110);

    // 0xA5C at CLK_DIV=2, sample toggled every cycle while in flight
    $display("[TB] frame 0xA5C");
    base = acc_cnt;
    applyStimulus(0, 12'hA5C, 1'b1);
    @(negedge clk);
    applyStimulus(0, 12'h3C3, 1'b0);
    checkOutput("a5c_accept", acc_cnt - base, 1);
    checkOutput("a5c_start", {busy, dac_dat, sample_ready}, {2'b11, HOLD});
    bad_ready = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy) break;
      sample = 12'($urandom);
      if (sample_ready !== HOLD) bad_ready++;
    end
    checkOutput("a5c_done", busy, 0);
    checkOutput("a5c_ready_in_frame", bad_ready, 0);
    checkOutput("a5c_ready_after", sample_ready, 1);
    checkOutput("a5c_latch", latch, 12'hA5C);
    checkOutput("a5c_rises", rise_cnt - rise_base, 12);
    checkOutput("a5c_first_rise", first_rise - acc_cyc, 2);
    checkOutput("a5c_leb_rise", leb_rise - acc_cyc, 50);
    checkOutput("a5c_leb_low", leb_rise - leb_fall, 2);
    checkOutput("a5c_frame_len", busy_fall - acc_cyc, FRAME_HALF_PERIODS * 2);

    // 0xFFF then 0x000 with sample_valid held high
    $display("[TB] back-to-back 0xFFF / 0x000");
    base      = acc_cnt;
    lbase     = latch_cnt;
    first_acc = 0;
    applyStimulus(0, 12'hFFF, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt - base >= 2) break;
      if (acc_cnt - base == 1) begin
        first_acc = acc_cyc;
        sample    = 12'h000;
      end
    end
    applyStimulus(0, 12'h000, 1'b0);
    checkOutput("b2b_accepts", acc_cnt - base, 2);
    checkOutput("b2b_accept_gap", acc_cyc - first_acc, HOLD ? 1 : 53);
    waitIdle("b2b_done", 250);
    checkOutput("b2b_latch_cnt", latch_cnt - lbase, 2);
    checkOutput("b2b_first_word", prev_latch, 12'hFFF);
    checkOutput("b2b_second_word", latch, 12'h000);
    checkOutput("b2b_frame_spacing", leb_rise - prev_leb_rise, HOLD ? 52 : 53);

    // Reset at the 5th dac_clk rise of 0x123
    $display("[TB] reset mid-frame");
    lbase = latch_cnt;
    applyStimulus(0, 12'h123, 1'b1);
    @(negedge clk);
    applyStimulus(0, 12'h000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (rise_cnt - rise_base >= 5) break;
      @(negedge clk);
    end
    checkOutput("mid_rise5", {dac_clk, rise_cnt - rise_base == 5}, 2'b11);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_outs", {dac_clk, dac_dat, dac_leb, dac_rst_b, sample_ready, busy}, 6'b001000);
    checkOutput("mid_dac_cleared", latch, 12'h000);
    checkOutput("mid_no_latch", latch_cnt - lbase, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 12'h456, 1'b1);
    @(negedge clk);
    applyStimulus(0, 12'h000, 1'b0);
    waitIdle("after_reset_done", 80);
    checkOutput("after_reset_latch", latch, 12'h456);
    checkOutput("after_reset_latch_cnt", latch_cnt - lbase, 1);

    // 0x801 at CLK_DIV=1
    $display("[TB] CLK_DIV=1 frame 0x801");
    base = acc_cnt_1;
    applyStimulus(1, 12'h801, 1'b1);
    @(negedge clk);
    applyStimulus(1, 12'h000, 1'b0);
    checkOutput("div1_accept", acc_cnt_1 - base, 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_1) break;
    end
    checkOutput("div1_done", busy_1, 0);
    checkOutput("div1_latch", latch_1, 12'h801);
    checkOutput("div1_first_rise", first_rise_1 - acc_cyc_1, 1);
    checkOutput("div1_leb_rise", leb_rise_1 - acc_cyc_1, 25);
    checkOutput("div1_frame_len", busy_fall_1 - acc_cyc_1, 26);
    checkOutput("div1_latch_cnt", latch_cnt_1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
